// File: rtl/stripe_scheduler_pkg.sv
// Shared constants, state encoding and stripe-length helper for the stripe scheduler.
package stripe_scheduler_pkg;

  localparam int STRIPE_W = 64;
  localparam int BASE_W   = 2;
  localparam int SCORE_W  = 14;
  localparam int COL_W    = 10;
  localparam int IDX_W    = 6;
  localparam int SEG_W    = STRIPE_W * BASE_W;

  localparam logic [SCORE_W-1:0] NEG_INF = 14'h3000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADQ,
    S_STREAM,
    S_WAIT_END,
    S_DONE
  } state_e;

  // Bases left to stream from col, clamped to the array window; 0 once col runs off the reference.
  function automatic logic [COL_W-1:0] stream_len(input logic [COL_W-1:0] col,
                                                  input logic [COL_W-1:0] ref_len,
                                                  input logic [COL_W-1:0] win);
    logic [COL_W-1:0] rem;
    rem = ref_len - col;
    if (col >= ref_len) begin
      rem = '0;
    end else if (rem > win) begin
      rem = win;
    end
    return rem;
  endfunction

endpackage

// File: rtl/stripe_scheduler_ref_streamer.sv
// Reference address generator with one-cycle memory latency compensation, so that
// each base on pe_a_o lines up with pe_start_o.
module stripe_scheduler_ref_streamer
  import stripe_scheduler_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              launch_i,
  input  logic [COL_W-1:0]  col_i,
  input  logic [COL_W-1:0]  len_i,
  input  logic [BASE_W-1:0] ref_data_i,
  output logic [COL_W-1:0]  ref_addr_o,
  output logic [BASE_W-1:0] pe_a_o,
  output logic              pe_start_o,
  output logic              active_o
);

  logic [COL_W-1:0]  addr_q, addr_d;
  logic [COL_W-1:0]  rem_q, rem_d;
  logic              fetch_vld;
  logic              data_vld_q;
  logic              start_q;
  logic [BASE_W-1:0] a_q;

  // While idle the address follows col_i, so the launch cycle already presents the first base.
  always_comb begin
    fetch_vld = launch_i ? (len_i != '0) : (rem_q != '0);
    addr_d    = col_i;
    rem_d     = '0;
    if (launch_i) begin
      addr_d = col_i + 1'b1;
      rem_d  = (len_i != '0) ? (len_i - 1'b1) : '0;
    end else if (rem_q != '0) begin
      addr_d = addr_q + 1'b1;
      rem_d  = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      rem_q      <= '0;
      data_vld_q <= 1'b0;
      start_q    <= 1'b0;
      a_q        <= '0;
    end else begin
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      data_vld_q <= fetch_vld;
      start_q    <= data_vld_q;
      a_q        <= data_vld_q ? ref_data_i : '0;
    end
  end

  assign ref_addr_o = addr_q;
  assign pe_a_o     = a_q;
  assign pe_start_o = start_q;
  // The final start cycle is already committed once both earlier stages are empty.
  assign active_o   = (rem_q != '0) || data_vld_q;

endmodule

// File: rtl/stripe_scheduler.sv
// Walks the systolic array across an alignment one 64-base query stripe at a time,
// advancing the reference column by the array's reported offset and tracking the best stripe.
module stripe_scheduler
  import stripe_scheduler_pkg::*;
#(
  parameter int WIN_LEN  = 400,
  parameter int WDOG_CYC = 1023
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_go,
  input  logic [IDX_W-1:0]   i_num_stripes,
  input  logic [COL_W-1:0]   i_ref_len,
  output logic [IDX_W-1:0]   o_qry_addr,
  input  logic [SEG_W-1:0]   i_qry_data,
  output logic [COL_W-1:0]   o_ref_addr,
  input  logic [BASE_W-1:0]  i_ref_data,
  output logic               o_pe_start,
  output logic [SEG_W-1:0]   o_pe_B,
  output logic [BASE_W-1:0]  o_pe_A,
  input  logic               i_stripe_end,
  input  logic [COL_W-1:0]   i_start_position,
  input  logic [SCORE_W-1:0] i_max_score_stripe,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [SCORE_W-1:0] o_best_score,
  output logic [IDX_W-1:0]   o_best_stripe
);

  localparam logic [COL_W-1:0] WIN_MAX   = COL_W'(WIN_LEN);
  localparam logic [COL_W-1:0] WDOG_LAST = COL_W'(WDOG_CYC - 1);

  state_e             state_q, state_d;
  logic               phase_q, phase_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [IDX_W-1:0]   stripe_q, stripe_d;
  logic [IDX_W-1:0]   nstripes_q, nstripes_d;
  logic [COL_W-1:0]   reflen_q, reflen_d;
  logic [SEG_W-1:0]   pe_b_q, pe_b_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic               err_q, err_d;
  logic [COL_W-1:0]   wdog_q, wdog_d;

  logic [COL_W-1:0]   len;
  logic               launch;
  logic               stream_active;
  logic [COL_W:0]     col_sum;
  logic [COL_W-1:0]   col_sat;
  logic [IDX_W:0]     stripe_nxt;
  logic               last_stripe;

  assign len         = stream_len(col_q, reflen_q, WIN_MAX);
  assign launch      = (state_q == S_LOADQ) && phase_q;
  assign col_sum     = {1'b0, col_q} + {1'b0, i_start_position};
  assign col_sat     = (col_sum > {1'b0, reflen_q}) ? reflen_q : col_sum[COL_W-1:0];
  assign stripe_nxt  = {1'b0, stripe_q} + 1'b1;
  assign last_stripe = (stripe_nxt == {1'b0, nstripes_q});

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    col_d      = col_q;
    stripe_d   = stripe_q;
    nstripes_d = nstripes_q;
    reflen_d   = reflen_q;
    pe_b_d     = pe_b_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    err_d      = err_q;
    wdog_d     = wdog_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_go) begin
          col_d      = '0;
          stripe_d   = '0;
          best_d     = NEG_INF;
          best_idx_d = '0;
          err_d      = 1'b0;
          phase_d    = 1'b0;
          nstripes_d = i_num_stripes;
          reflen_d   = i_ref_len;
          state_d    = (i_num_stripes == '0) ? S_DONE : S_LOADQ;
        end
      end

      // Second cycle: query segment has arrived and the first ref base is being fetched.
      // A stripe whose column is past the reference end is skipped without waiting on the array.
      S_LOADQ: begin
        phase_d = 1'b1;
        if (phase_q) begin
          phase_d = 1'b0;
          pe_b_d  = i_qry_data;
          if (len == '0) begin
            stripe_d = stripe_nxt[IDX_W-1:0];
            state_d  = last_stripe ? S_DONE : S_LOADQ;
          end else begin
            state_d = S_STREAM;
          end
        end
      end

      S_STREAM: begin
        if (!stream_active) begin
          wdog_d  = '0;
          state_d = S_WAIT_END;
        end
      end

      S_WAIT_END: begin
        wdog_d = wdog_q + 1'b1;
        if (i_stripe_end) begin
          if ($signed(i_max_score_stripe) > $signed(best_q)) begin
            best_d     = i_max_score_stripe;
            best_idx_d = stripe_q;
          end
          col_d    = col_sat;
          stripe_d = stripe_nxt[IDX_W-1:0];
          state_d  = last_stripe ? S_DONE : S_LOADQ;
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      col_q      <= '0;
      stripe_q   <= '0;
      nstripes_q <= '0;
      reflen_q   <= '0;
      pe_b_q     <= '0;
      best_q     <= NEG_INF;
      best_idx_q <= '0;
      err_q      <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      col_q      <= col_d;
      stripe_q   <= stripe_d;
      nstripes_q <= nstripes_d;
      reflen_q   <= reflen_d;
      pe_b_q     <= pe_b_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
    end
  end

  stripe_scheduler_ref_streamer u_ref_streamer (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .launch_i   (launch),
    .col_i      (col_q),
    .len_i      (len),
    .ref_data_i (i_ref_data),
    .ref_addr_o (o_ref_addr),
    .pe_a_o     (o_pe_A),
    .pe_start_o (o_pe_start),
    .active_o   (stream_active)
  );

  assign o_qry_addr    = stripe_q;
  assign o_pe_B        = pe_b_q;
  assign o_busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done        = (state_q == S_DONE);
  assign o_err         = err_q;
  assign o_best_score  = best_q;
  assign o_best_stripe = best_idx_q;

endmodule

// File: tb/tb_stripe_scheduler.sv
// Directed self-checking bench for stripe_scheduler: models the query/reference buffers
// and plays the array's stripe-end responses by hand.
`timescale 1ns/1ps
module tb_stripe_scheduler;

  logic         clk = 1'b0;
  logic         rstN;
  logic         go;
  logic [5:0]   numStripes;
  logic [9:0]   refLen;
  logic [5:0]   qryAddr;
  logic [127:0] qryData;
  logic [9:0]   refAddr;
  logic [1:0]   refData;
  logic         peStart;
  logic [127:0] peB;
  logic [1:0]   peA;
  logic         stripeEnd;
  logic [9:0]   startPos;
  logic [13:0]  maxScore;
  logic         busy;
  logic         done;
  logic         err;
  logic [13:0]  bestScore;
  logic [5:0]   bestStripe;

  logic [1:0]   refMem [0:1023];
  logic [127:0] qryMem [0:63];

  int           cyc = 0;
  int           assertCount = 0;
  int           failCount = 0;

  logic [1:0]   capA [$];
  int           riseCount = 0;
  int           lastRiseCyc = 0;
  int           lastStartCyc = 0;
  int           doneCount = 0;
  logic [127:0] bAtRise = '0;
  logic         prevStart = 1'b0;

  always #5 clk = ~clk;

  stripe_scheduler dut (
    .i_clk              (clk),
    .i_rst_n            (rstN),
    .i_go               (go),
    .i_num_stripes      (numStripes),
    .i_ref_len          (refLen),
    .o_qry_addr         (qryAddr),
    .i_qry_data         (qryData),
    .o_ref_addr         (refAddr),
    .i_ref_data         (refData),
    .o_pe_start         (peStart),
    .o_pe_B             (peB),
    .o_pe_A             (peA),
    .i_stripe_end       (stripeEnd),
    .i_start_position   (startPos),
    .i_max_score_stripe (maxScore),
    .o_busy             (busy),
    .o_done             (done),
    .o_err              (err),
    .o_best_score       (bestScore),
    .o_best_stripe      (bestStripe)
  );

  // Buffer model: one cycle of read latency on both memories.
  always @(posedge clk) begin
    refData <= refMem[refAddr];
    qryData <= qryMem[qryAddr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Capture everything the array would see, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (peStart) begin
      capA.push_back(peA);
      lastStartCyc = cyc;
      if (!prevStart) begin
        riseCount++;
        lastRiseCyc = cyc;
        bAtRise = peB;
      end
    end
    prevStart = peStart;
    if (done) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearCapture();
    capA.delete();
    riseCount = 0;
  endtask

  task automatic applyStimulus(input logic [5:0] n, input logic [9:0] len, output int goCyc);
    @(negedge clk);
    numStripes = n;
    refLen = len;
    go = 1'b1;
    goCyc = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  // Waits out one stripe's stream, checks it, then optionally plays the array's end report.
  task automatic runStripe(input string tag, input int expCol, input int expLen, input int expSeg,
                           input logic [9:0] pos, input logic [13:0] score, input bit sendEnd);
    int waited;
    int bad;
    waited = 0;
    bad = 0;
    while (!peStart && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, " start seen"}, 128'(peStart), 128'(1));
    waited = 0;
    while (peStart && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, " start ended"}, 128'(peStart), 128'(0));
    @(negedge clk);
    checkOutput({tag, " stream length"}, 128'(capA.size()), 128'(expLen));
    checkOutput({tag, " single burst"}, 128'(riseCount), 128'(1));
    for (int i = 0; i < capA.size(); i++) begin
      if (capA[i] !== refMem[expCol + i]) bad++;
    end
    checkOutput({tag, " A data errors"}, 128'(bad), 128'(0));
    checkOutput({tag, " B segment"}, bAtRise, qryMem[expSeg]);
    if (sendEnd) begin
      stripeEnd = 1'b1;
      startPos = pos;
      maxScore = score;
    end
    @(negedge clk);
    stripeEnd = 1'b0;
    clearCapture();
  endtask

  task automatic waitDone(input string tag, input int maxCyc, output int dCyc);
    int waited;
    waited = 0;
    while (!done && waited < maxCyc) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, " done pulse"}, 128'(done), 128'(1));
    checkOutput({tag, " busy low at done"}, 128'(busy), 128'(0));
    dCyc = cyc;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int g;
    int d;
    int doneBefore;
    rstN = 1'b0;
    go = 1'b0;
    numStripes = '0;
    refLen = '0;
    stripeEnd = 1'b0;
    startPos = '0;
    maxScore = '0;
    for (int i = 0; i < 1024; i++) refMem[i] = 2'(i ^ (i >> 3));
    for (int s = 0; s < 64; s++) begin
      qryMem[s] = '0;
      for (int k = 0; k < 64; k++) qryMem[s][2*k +: 2] = 2'(s + 3 * k);
    end

    repeat (3) @(negedge clk);
    checkOutput("reset best score", 128'(bestScore), 128'(14'h3000));
    checkOutput("reset best stripe", 128'(bestStripe), 128'(0));
    checkOutput("reset busy", 128'(busy), 128'(0));
    checkOutput("reset done", 128'(done), 128'(0));
    checkOutput("reset err", 128'(err), 128'(0));
    checkOutput("reset pe_start", 128'(peStart), 128'(0));
    checkOutput("reset ref addr", 128'(refAddr), 128'(0));
    checkOutput("reset pe_B", peB, 128'(0));
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    clearCapture();

    $display("[TB] single stripe, ref_len=100");
    applyStimulus(6'd1, 10'd100, g);
    repeat (8) @(negedge clk);
    checkOutput("T1 busy mid-stream", 128'(busy), 128'(1));
    go = 1'b1;
    numStripes = 6'd5;
    @(negedge clk);
    go = 1'b0;
    numStripes = 6'd1;
    runStripe("T1 s0", 0, 100, 0, 10'd37, 14'd123, 1'b1);
    checkOutput("T1 first start latency", 128'(lastRiseCyc - g), 128'(4));
    waitDone("T1", 20, d);
    checkOutput("T1 best score", 128'(bestScore), 128'(14'd123));
    checkOutput("T1 best stripe", 128'(bestStripe), 128'(0));
    checkOutput("T1 err", 128'(err), 128'(0));
    @(negedge clk);
    checkOutput("T1 done one cycle", 128'(done), 128'(0));

    $display("[TB] three stripes, column advance and tie handling");
    clearCapture();
    applyStimulus(6'd3, 10'd300, g);
    runStripe("T2 s0", 0, 300, 0, 10'd10, 14'd50, 1'b1);
    runStripe("T2 s1", 10, 290, 1, 10'd20, 14'd80, 1'b1);
    runStripe("T2 s2", 30, 270, 2, 10'd5, 14'd80, 1'b1);
    waitDone("T2", 20, d);
    checkOutput("T2 best score", 128'(bestScore), 128'(14'd80));
    checkOutput("T2 best stripe", 128'(bestStripe), 128'(1));

    $display("[TB] window clamp and column saturation");
    clearCapture();
    applyStimulus(6'd2, 10'd500, g);
    runStripe("T3 s0", 0, 400, 0, 10'd600, 14'h3FFB, 1'b1);
    waitDone("T3", 20, d);
    @(negedge clk);
    checkOutput("T3 skipped stripe streams nothing", 128'(capA.size()), 128'(0));
    checkOutput("T3 best score", 128'(bestScore), 128'(14'h3FFB));
    checkOutput("T3 best stripe", 128'(bestStripe), 128'(0));

    $display("[TB] watchdog abort");
    clearCapture();
    applyStimulus(6'd1, 10'd10, g);
    runStripe("T4 s0", 0, 10, 0, 10'd0, 14'd0, 1'b0);
    waitDone("T4", 1100, d);
    checkOutput("T4 watchdog timing", 128'(d - lastStartCyc), 128'(1024));
    checkOutput("T4 err raised", 128'(err), 128'(1));
    repeat (4) @(negedge clk);
    checkOutput("T4 err sticky", 128'(err), 128'(1));
    applyStimulus(6'd0, 10'd10, g);
    checkOutput("T4 zero-stripe done", 128'(done), 128'(1));
    checkOutput("T4 zero-stripe done latency", 128'(cyc - g), 128'(1));
    checkOutput("T4 err cleared by go", 128'(err), 128'(0));
    @(negedge clk);
    checkOutput("T4 zero-stripe done one cycle", 128'(done), 128'(0));

    $display("[TB] reset during streaming");
    clearCapture();
    applyStimulus(6'd1, 10'd200, g);
    repeat (10) @(negedge clk);
    checkOutput("T5 streaming before reset", 128'(peStart), 128'(1));
    doneBefore = doneCount;
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("T5 pe_start after reset", 128'(peStart), 128'(0));
    checkOutput("T5 busy after reset", 128'(busy), 128'(0));
    checkOutput("T5 pe_B after reset", peB, 128'(0));
    checkOutput("T5 ref addr after reset", 128'(refAddr), 128'(0));
    checkOutput("T5 best after reset", 128'(bestScore), 128'(14'h3000));
    rstN = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("T5 no done from reset", 128'(doneCount - doneBefore), 128'(0));
    checkOutput("T5 stays idle", 128'(peStart), 128'(0));
    applyStimulus(6'd0, 10'd200, g);
    checkOutput("T5 zero-stripe done after reset", 128'(done), 128'(1));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
